branch_predictor: RTL and testbench

Parametrised dynamic branch predictor (direct-mapped BTB plus saturating-counter direction table) for the 5-stage RV32I pipeline. It replaces the static "predict not-taken, resolve in EX, flush IF/ID and ID/EX" policy. IF queries it every fetch with the current PC. EX reports each resolved branch; the block updates its table and flags mispredictions so the top level redirects and flushes only on a wrong guess.

---
 rtl/bp_pkg.sv | 41 ++++
 rtl/sat_event_counter.sv | 24 ++
 rtl/branch_predictor.sv | 96 +++++++++
 tb/tb_branch_predictor.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the branch predictor.
// Entry fields are sized for the widest supported configuration; the top slices them.
package bp_pkg;

  localparam int XLEN_MAX  = 64;
  localparam int CTR_W_MAX = 8;

  typedef logic [CTR_W_MAX-1:0] ctr_t;

  typedef struct packed {
    logic                valid;
    logic [XLEN_MAX-1:0] tag;
    logic [XLEN_MAX-1:0] target;
    ctr_t                ctr;
  } bp_entry_t;

  function automatic ctr_t ctr_max(input int w);
    return ctr_t'((1 << w) - 1);
  endfunction

  function automatic ctr_t ctr_weak_t(input int w);
    return ctr_t'(1 << (w - 1));
  endfunction

  function automatic ctr_t ctr_weak_nt(input int w);
    return ctr_t'((1 << (w - 1)) - 1);
  endfunction

  // Saturating step: climbs toward max on taken, falls toward zero otherwise.
  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken, input ctr_t max);
    ctr_t r;
    r = ctr;
    if (taken) begin
      if (ctr != max) r = ctr + ctr_t'(1);
    end else begin
      if (ctr != '0) r = ctr - ctr_t'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_event_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Count is registered: an inc shows up one cycle later; never stalls.
module sat_event_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters; lookup and mispredict are combinational,
// table updates land on the next edge with no bypass, and the block never applies backpressure.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   if_pc,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic              ex_taken,
  input  logic [XLEN-1:0]   ex_target,
  input  logic              ex_pred_taken,
  input  logic [XLEN-1:0]   ex_pred_target,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - 2 - IDX_W;

  localparam ctr_t CTR_MAX     = ctr_max(CTR_W);
  localparam ctr_t CTR_WEAK_T  = ctr_weak_t(CTR_W);
  localparam ctr_t CTR_WEAK_NT = ctr_weak_nt(CTR_W);

  bp_entry_t r_tbl [ENTRIES];

  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic             w_if_hit;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_hit;
  logic             w_ex_vld;

  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_if_tag = if_pc[XLEN-1:IDX_W+2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_ex_tag = ex_pc[XLEN-1:IDX_W+2];

  assign w_if_hit = r_tbl[w_if_idx].valid && (r_tbl[w_if_idx].tag == XLEN_MAX'(w_if_tag));
  assign w_ex_hit = r_tbl[w_ex_idx].valid && (r_tbl[w_ex_idx].tag == XLEN_MAX'(w_ex_tag));

  // Table may still hold stale valid bits in the reset cycle, so the prediction is gated too.
  assign pred_taken  = ~reset & w_if_hit & r_tbl[w_if_idx].ctr[CTR_W-1];
  assign pred_target = pred_taken ? r_tbl[w_if_idx].target[XLEN-1:0] : if_pc + XLEN'(4);

  assign w_ex_vld    = ex_valid & ~reset;
  assign mispredict  = w_ex_vld & ((ex_taken != ex_pred_taken) |
                                   (ex_taken & (ex_target != ex_pred_target)));
  assign redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);

  // Only valid and ctr are reset; tag/target are qualified by valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_tbl[i].valid <= 1'b0;
        r_tbl[i].ctr   <= CTR_WEAK_NT;
      end
    end else if (ex_valid) begin
      if (w_ex_hit) begin
        r_tbl[w_ex_idx].ctr <= ctr_next(r_tbl[w_ex_idx].ctr, ex_taken, CTR_MAX);
        if (ex_taken) r_tbl[w_ex_idx].target <= XLEN_MAX'(ex_target);
      end else if (ex_taken) begin
        r_tbl[w_ex_idx] <= '{valid:  1'b1,
                             tag:    XLEN_MAX'(w_ex_tag),
                             target: XLEN_MAX'(ex_target),
                             ctr:    CTR_WEAK_T};
      end
    end
  end

  sat_event_counter #(.W(STAT_W)) u_stat_branches (
    .clk   (clk),
    .reset (reset),
    .inc   (w_ex_vld),
    .count (stat_branches)
  );

  sat_event_counter #(.W(STAT_W)) u_stat_mispredicts (
    .clk   (clk),
    .reset (reset),
    .inc   (mispredict),
    .count (stat_mispredicts)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: default-config predictor plus a STAT_W=4 copy on the same stimulus.
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] if_pc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;

  logic        pred_taken;
  logic [31:0] pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  logic        pt4;
  logic [31:0] ptg4;
  logic        mp4;
  logic [31:0] rd4;
  logic [3:0]  sb4;
  logic [3:0]  sm4;

  int n_checks = 0;
  int n_errors = 0;

  branch_predictor u_dut (
    .clk              (clk),
    .reset            (reset),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  branch_predictor #(.STAT_W(4)) u_dut4 (
    .clk              (clk),
    .reset            (reset),
    .if_pc            (if_pc),
    .pred_taken       (pt4),
    .pred_target      (ptg4),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .mispredict       (mp4),
    .redirect_pc      (rd4),
    .stat_branches    (sb4),
    .stat_mispredicts (sm4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one resolved branch, check the combinational mispredict, then clock it in.
  task automatic step(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                      input logic ptk, input logic [31:0] ptgt, input logic exp_mp,
                      input string tag);
    ex_valid       = 1'b1;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
    #1;
    chk(tag, {31'd0, mispredict}, {31'd0, exp_mp});
    tick();
  endtask

  initial begin
    reset = 1'b1; if_pc = 32'h14;
    ex_valid = 1'b1; ex_pc = 32'h14; ex_taken = 1'b1; ex_target = 32'h1C;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h18;
    tick();
    chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
    chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_pred_target", pred_target, 32'h18);
    tick();
    reset = 1'b0; ex_valid = 1'b0;
    #1;
    chk("post_rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("post_rst_pred_target", pred_target, 32'h18);
    chk("post_rst_stat_br", stat_branches, 32'd0);
    chk("post_rst_stat_mp", stat_mispredicts, 32'd0);

    // Taken allocate at 0x14; same-cycle lookup must still miss
    ex_valid = 1'b1; ex_pc = 32'h14; ex_taken = 1'b1; ex_target = 32'h1C;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h18;
    #1;
    chk("alloc_mispredict", {31'd0, mispredict}, 32'd1);
    chk("alloc_redirect", redirect_pc, 32'h1C);
    chk("alloc_sameclk_pred", {31'd0, pred_taken}, 32'd0);
    tick();
    ex_valid = 1'b0;
    #1;
    chk("alloc_next_pred", {31'd0, pred_taken}, 32'd1);
    chk("alloc_next_target", pred_target, 32'h1C);
    chk("alloc_stat_br", stat_branches, 32'd1);
    chk("alloc_stat_mp", stat_mispredicts, 32'd1);

    // Counter walks 2->1->0->0
    ex_valid = 1'b1; ex_pc = 32'h14; ex_taken = 1'b0; ex_pred_taken = 1'b1;
    #1;
    chk("nt_redirect", redirect_pc, 32'h18);
    tick();
    chk("nt1_pred", {31'd0, pred_taken}, 32'd0);
    chk("nt1_target", pred_target, 32'h18);
    step(32'h14, 1'b0, 32'h1C, 1'b0, 32'h18, 1'b0, "nt2_mispredict");
    step(32'h14, 1'b0, 32'h1C, 1'b0, 32'h18, 1'b0, "nt3_mispredict");
    chk("nt_stat_br", stat_branches, 32'd4);
    chk("nt_stat_mp", stat_mispredicts, 32'd2);
    chk("nt_stat4_br", {28'd0, sb4}, 32'd4);
    chk("nt3_pred", {31'd0, pred_taken}, 32'd0);

    // From 0: a taken gives 1 (still not-taken), a second gives 2 with the new target
    step(32'h14, 1'b1, 32'h1C, 1'b0, 32'h18, 1'b1, "tk1_mispredict");
    chk("tk1_pred", {31'd0, pred_taken}, 32'd0);
    step(32'h14, 1'b1, 32'h40, 1'b0, 32'h18, 1'b1, "tk2_mispredict");
    chk("tk2_pred", {31'd0, pred_taken}, 32'd1);
    chk("tk2_target", pred_target, 32'h40);
    step(32'h14, 1'b1, 32'h40, 1'b1, 32'h44, 1'b1, "tgt_mismatch_mispredict");
    step(32'h14, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, "tk_match_mispredict");
    step(32'h14, 1'b0, 32'h40, 1'b1, 32'h40, 1'b1, "sat_nt_mispredict");
    chk("sat_top_pred", {31'd0, pred_taken}, 32'd1);
    chk("sat_top_target", pred_target, 32'h40);
    chk("sat_stat_br", stat_branches, 32'd9);
    chk("sat_stat_mp", stat_mispredicts, 32'd6);

    // Aliasing on index 5
    ex_valid = 1'b0; if_pc = 32'h54;
    #1;
    chk("alias_miss_pred", {31'd0, pred_taken}, 32'd0);
    chk("alias_miss_target", pred_target, 32'h58);
    step(32'h54, 1'b1, 32'h80, 1'b0, 32'h58, 1'b1, "alias_alloc_mispredict");
    chk("alias_hit_pred", {31'd0, pred_taken}, 32'd1);
    chk("alias_hit_target", pred_target, 32'h80);
    if_pc = 32'h14;
    #1;
    chk("alias_evicted_pred", {31'd0, pred_taken}, 32'd0);
    chk("alias_evicted_target", pred_target, 32'h18);
    step(32'h14, 1'b0, 32'h18, 1'b0, 32'h18, 1'b0, "nt_miss_mispredict");
    if_pc = 32'h54;
    #1;
    chk("nt_no_alloc_pred", {31'd0, pred_taken}, 32'd1);
    chk("nt_no_alloc_target", pred_target, 32'h80);

    // Same-cycle lookup/update of 0x14
    if_pc = 32'h14;
    ex_valid = 1'b1; ex_pc = 32'h14; ex_taken = 1'b1; ex_target = 32'h30;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h18;
    #1;
    chk("same_clk_pred", {31'd0, pred_taken}, 32'd0);
    chk("same_clk_target", pred_target, 32'h18);
    tick();
    ex_valid = 1'b0;
    #1;
    chk("next_clk_pred", {31'd0, pred_taken}, 32'd1);
    chk("next_clk_target", pred_target, 32'h30);
    chk("same_stat_br", stat_branches, 32'd12);
    chk("same_stat_mp", stat_mispredicts, 32'd8);

    // Address wrap on both +4 paths
    if_pc = 32'hFFFF_FFFC;
    ex_valid = 1'b1; ex_pc = 32'hFFFF_FFFC; ex_taken = 1'b0; ex_pred_taken = 1'b1;
    #1;
    chk("wrap_pred_target", pred_target, 32'h0);
    chk("wrap_redirect", redirect_pc, 32'h0);
    tick();
    ex_valid = 1'b0;

    // Saturating stats and mid-burst reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("burst_pre_stat4_br", {28'd0, sb4}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      step(32'h100 + 32'(4 * i), 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, "burst_mispredict");
    end
    chk("burst_stat4_br", {28'd0, sb4}, 32'd15);
    chk("burst_stat4_mp", {28'd0, sm4}, 32'd15);
    chk("burst_stat32_br", stat_branches, 32'd20);
    chk("burst_stat32_mp", stat_mispredicts, 32'd20);
    if_pc = 32'h14C;
    #1;
    chk("burst_trained_pred", {31'd0, pred_taken}, 32'd1);
    chk("burst_trained_target", pred_target, 32'h300);

    reset = 1'b1;
    ex_valid = 1'b1; ex_pc = 32'h200; ex_taken = 1'b1; ex_target = 32'h400;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h204;
    #1;
    chk("midrst_mispredict", {31'd0, mispredict}, 32'd0);
    chk("midrst_pred", {31'd0, pred_taken}, 32'd0);
    chk("midrst_target", pred_target, 32'h150);
    tick();
    reset = 1'b0; ex_valid = 1'b0;
    #1;
    chk("midrst_stat4_br", {28'd0, sb4}, 32'd0);
    chk("midrst_stat4_mp", {28'd0, sm4}, 32'd0);
    chk("midrst_empty_pred", {31'd0, pred_taken}, 32'd0);
    if_pc = 32'h200;
    #1;
    chk("midrst_discard_pred", {31'd0, pred_taken}, 32'd0);
    chk("midrst_discard_target", pred_target, 32'h204);
    tick();
    chk("midrst_stat32_br", stat_branches, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
